ysyx_22040125_fwd_ctrl: RTL

YSYX_22040125_FWD_CTRL -- requirements
Module: ysyx_22040125_FWD_CTRL

---
 rtl/ysyx_22040125_fwd_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040125_fwd_ctrl.sv
// Operand-forwarding and hazard controller: registered EXE operand selects plus
// combinational stall/bubble controls driven by a RUN / LU / MCW state machine.
module ysyx_22040125_fwd_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic       exe_valid,
   input  logic       exe_wen,
   input  logic       exe_is_load,
   input  logic [4:0] exe_rd,
   input  logic       mem_valid,
   input  logic       mem_wen,
   input  logic [4:0] mem_rd,
   input  logic       exe_mc_req,
   input  logic       exe_mc_done,
   input  logic       exe_redirect,
   output logic [2:0] src1_sel_plus,
   output logic [2:0] src2_sel_plus,
   output logic       stall_front,
   output logic       stall_all,
   output logic       bubble_exe,
   output logic [1:0] fsm_state
);

   localparam logic [1:0] ST_RUN = 2'b00;
   localparam logic [1:0] ST_LU  = 2'b01;
   localparam logic [1:0] ST_MCW = 2'b10;

   function automatic logic hit(input logic v, input logic w,
                                input logic [4:0] rd, input logic [4:0] rs);
      return v & w & (rd != 5'd0) & (rd == rs);
   endfunction

   // EXE is the younger producer, so it takes priority over MEM.
   function automatic logic [2:0] sel_of(input logic used, input logic he, input logic hm);
      logic [2:0] s;
      if (!used)   s = 3'b001;
      else if (he) s = 3'b010;
      else if (hm) s = 3'b100;
      else         s = 3'b001;
      return s;
   endfunction

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [2:0] sel1_r, sel2_r;
   logic       he1_s, he2_s, hm1_s, hm2_s;
   logic       load_use_s;
   logic       stall_all_s, stall_front_s, bubble_s;
   logic [2:0] sel1_nxt_s, sel2_nxt_s;

   assign he1_s = hit(exe_valid, exe_wen, exe_rd, id_rs1);
   assign he2_s = hit(exe_valid, exe_wen, exe_rd, id_rs2);
   assign hm1_s = hit(mem_valid, mem_wen, mem_rd, id_rs1);
   assign hm2_s = hit(mem_valid, mem_wen, mem_rd, id_rs2);
   assign sel1_nxt_s = sel_of(id_rs1_used, he1_s, hm1_s);
   assign sel2_nxt_s = sel_of(id_rs2_used, he2_s, hm2_s);
   assign load_use_s = id_valid & exe_is_load &
                       ((id_rs1_used & he1_s) | (id_rs2_used & he2_s));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: a freeze dominates, then redirect, then load-use
   always_comb begin
      state_nxt_s = ST_RUN;
      if (stall_all_s) begin
         state_nxt_s = ST_MCW;
      end else if (exe_redirect) begin
         state_nxt_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN:  state_nxt_s = load_use_s ? ST_LU : ST_RUN;
            default: state_nxt_s = ST_RUN;
         endcase
      end
   end

   // Output logic: stall/bubble controls, forced low during reset
   always_comb begin
      stall_all_s   = 1'b0;
      stall_front_s = 1'b0;
      bubble_s      = 1'b0;
      if (rst) begin
         stall_all_s   = 1'b0;
         stall_front_s = 1'b0;
         bubble_s      = 1'b0;
      end else begin
         case (state_r)
            ST_MCW:        stall_all_s = ~exe_mc_done;
            ST_RUN, ST_LU: stall_all_s = exe_mc_req & ~exe_mc_done;
            default:       stall_all_s = 1'b0;
         endcase
         // Redirect is ignored under a freeze; the producer re-presents it afterwards.
         if (stall_all_s) begin
            stall_front_s = 1'b0;
            bubble_s      = 1'b0;
         end else if (exe_redirect) begin
            stall_front_s = 1'b0;
            bubble_s      = 1'b1;
         end else if ((state_r == ST_RUN) && load_use_s) begin
            stall_front_s = 1'b1;
            bubble_s      = 1'b1;
         end else begin
            stall_front_s = 1'b0;
            bubble_s      = 1'b0;
         end
      end
   end

   // Operand-select registers: hold on freeze, normal path on bubble or empty ID
   always_ff @(posedge clk) begin
      if (rst) begin
         sel1_r <= 3'b001;
         sel2_r <= 3'b001;
      end else if (stall_all_s) begin
         sel1_r <= sel1_r;
         sel2_r <= sel2_r;
      end else if (bubble_s || !id_valid) begin
         sel1_r <= 3'b001;
         sel2_r <= 3'b001;
      end else begin
         sel1_r <= sel1_nxt_s;
         sel2_r <= sel2_nxt_s;
      end
   end

   assign src1_sel_plus = sel1_r;
   assign src2_sel_plus = sel2_r;
   assign stall_all     = stall_all_s;
   assign stall_front   = stall_front_s;
   assign bubble_exe    = bubble_s;
   assign fsm_state     = state_r;

endmodule
